// File: rtl/uart_link_p.sv
// UART transceiver with a configurable frame format, TX/RX FIFOs, sticky error flags and an
// internal loopback path. The tick is 16x oversampled; one bit lasts 16 ticks.
module uart_link_p #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DBITS    = 8,
  parameter int unsigned PARITY   = 0,
  parameter int unsigned SBITS    = 1,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_uart,
  input  logic [DBITS-1:0] w_data,
  output logic             tx_full,
  input  logic             rd_uart,
  output logic [DBITS-1:0] r_data,
  output logic             rx_empty,
  input  logic             rx,
  output logic             tx,
  input  logic             loopback,
  input  logic             err_clr,
  output logic             err_parity,
  output logic             err_frame,
  output logic             err_overrun
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [4:0] STOP_LAST = 5'(SBITS * 16 - 1);
  localparam logic [2:0] DLAST = 3'(DBITS - 1);
  localparam logic PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Free-running baud tick.
  logic [DW-1:0] div_q;
  logic          tick;
  assign tick = (div_q == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)      div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DW'(1);
  end

  // TX FIFO
  logic [DBITS-1:0]   txf_mem [DEPTH];
  logic [FIFO_AW-1:0] txf_wp, txf_rp;
  logic [FIFO_AW:0]   txf_cnt, txf_cnt_d;
  logic               txf_push, txf_pop;

  assign txf_push = wr_uart && ((txf_cnt != FULL_CNT) || txf_pop);

  always_comb begin
    txf_cnt_d = txf_cnt;
    if (txf_push && !txf_pop)      txf_cnt_d = txf_cnt + (FIFO_AW + 1)'(1);
    else if (!txf_push && txf_pop) txf_cnt_d = txf_cnt - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wp] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      txf_wp  <= '0;
      txf_rp  <= '0;
      txf_cnt <= '0;
      tx_full <= 1'b0;
    end else begin
      if (txf_push) txf_wp <= txf_wp + FIFO_AW'(1);
      if (txf_pop)  txf_rp <= txf_rp + FIFO_AW'(1);
      txf_cnt <= txf_cnt_d;
      tx_full <= (txf_cnt_d == FULL_CNT);
    end
  end

  // TX FSM; the line is registered so it trails the state by one cycle.
  state_e           tx_st;
  logic [4:0]       tx_tcnt;
  logic [2:0]       tx_bcnt;
  logic [DBITS-1:0] tx_sh;
  logic             tx_par, tx_line_q, tx_bit;

  assign txf_pop = (txf_cnt != '0) &&
                   ((tx_st == StIdle) || ((tx_st == StStop) && tick && (tx_tcnt == STOP_LAST)));

  always_comb begin
    case (tx_st)
      StStart:  tx_bit = 1'b0;
      StData:   tx_bit = tx_sh[0];
      StParity: tx_bit = tx_par;
      default:  tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st     <= StIdle;
      tx_tcnt   <= '0;
      tx_bcnt   <= '0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      tx_line_q <= 1'b1;
      tx        <= 1'b1;
    end else begin
      tx_line_q <= tx_bit;
      tx        <= tx_bit | loopback;
      if (txf_pop) begin
        tx_st   <= StStart;
        tx_tcnt <= '0;
        tx_sh   <= txf_mem[txf_rp];
        tx_par  <= (^txf_mem[txf_rp]) ^ PAR_ODD;
      end else if (tick) begin
        case (tx_st)
          StStart: begin
            if (tx_tcnt == 5'd15) begin
              tx_st   <= StData;
              tx_tcnt <= '0;
              tx_bcnt <= '0;
            end else tx_tcnt <= tx_tcnt + 5'd1;
          end
          StData: begin
            if (tx_tcnt == 5'd15) begin
              tx_tcnt <= '0;
              tx_sh   <= {1'b0, tx_sh[DBITS-1:1]};
              if (tx_bcnt == DLAST) tx_st <= (PARITY != 0) ? StParity : StStop;
              else                  tx_bcnt <= tx_bcnt + 3'd1;
            end else tx_tcnt <= tx_tcnt + 5'd1;
          end
          StParity: begin
            if (tx_tcnt == 5'd15) begin
              tx_st   <= StStop;
              tx_tcnt <= '0;
            end else tx_tcnt <= tx_tcnt + 5'd1;
          end
          StStop: begin
            if (tx_tcnt == STOP_LAST) tx_st <= StIdle;
            else                      tx_tcnt <= tx_tcnt + 5'd1;
          end
          default: tx_st <= StIdle;
        endcase
      end
    end
  end

  // RX input: synchroniser, then the live loopback mux.
  logic [1:0] sync_q;
  logic       rx_line;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx};
  end

  assign rx_line = loopback ? tx_line_q : sync_q[1];

  // RX FSM
  state_e           rx_st;
  logic [3:0]       rx_tcnt;
  logic [2:0]       rx_bcnt;
  logic [DBITS-1:0] rx_sh;
  logic             rx_par, stop_smp, par_ok, frame_bad, par_bad, rx_good, overrun;

  assign stop_smp  = (rx_st == StStop) && tick && (rx_tcnt == 4'd15);
  assign par_ok    = (PARITY == 0) || (rx_par == ((^rx_sh) ^ PAR_ODD));
  assign frame_bad = stop_smp && !rx_line;
  assign par_bad   = stop_smp && rx_line && !par_ok;
  assign rx_good   = stop_smp && rx_line && par_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_st   <= StIdle;
      rx_tcnt <= '0;
      rx_bcnt <= '0;
      rx_sh   <= '0;
      rx_par  <= 1'b0;
    end else begin
      case (rx_st)
        StIdle: if (!rx_line) begin
          rx_st   <= StStart;
          rx_tcnt <= '0;
        end
        StStart: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_st   <= rx_line ? StIdle : StData;
            rx_tcnt <= '0;
            rx_bcnt <= '0;
          end else rx_tcnt <= rx_tcnt + 4'd1;
        end
        StData: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_sh <= {rx_line, rx_sh[DBITS-1:1]};
            if (rx_bcnt == DLAST) rx_st <= (PARITY != 0) ? StParity : StStop;
            else                  rx_bcnt <= rx_bcnt + 3'd1;
          end
        end
        StParity: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_par <= rx_line;
            rx_st  <= StStop;
          end
        end
        StStop: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_st <= StIdle;
        end
        default: rx_st <= StIdle;
      endcase
    end
  end

  // RX FIFO
  logic [DBITS-1:0]   rxf_mem [DEPTH];
  logic [FIFO_AW-1:0] rxf_wp, rxf_rp;
  logic [FIFO_AW:0]   rxf_cnt, rxf_cnt_d;
  logic               rxf_push, rxf_pop;

  assign rxf_pop  = rd_uart && (rxf_cnt != '0);
  assign rxf_push = rx_good && ((rxf_cnt != FULL_CNT) || rxf_pop);
  assign overrun  = rx_good && !rxf_push;
  assign r_data   = rx_empty ? '0 : rxf_mem[rxf_rp];

  always_comb begin
    rxf_cnt_d = rxf_cnt;
    if (rxf_push && !rxf_pop)      rxf_cnt_d = rxf_cnt + (FIFO_AW + 1)'(1);
    else if (!rxf_push && rxf_pop) rxf_cnt_d = rxf_cnt - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem[rxf_wp] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxf_wp      <= '0;
      rxf_rp      <= '0;
      rxf_cnt     <= '0;
      rx_empty    <= 1'b1;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (rxf_push) rxf_wp <= rxf_wp + FIFO_AW'(1);
      if (rxf_pop)  rxf_rp <= rxf_rp + FIFO_AW'(1);
      rxf_cnt  <= rxf_cnt_d;
      rx_empty <= (rxf_cnt_d == '0);
      // A new error in the same cycle as err_clr leaves the flag set.
      err_parity  <= (err_parity & ~err_clr) | par_bad;
      err_frame   <= (err_frame & ~err_clr) | frame_bad;
      err_overrun <= (err_overrun & ~err_clr) | overrun;
    end
  end

endmodule

// File: tb/tb_uart_link_p.sv
// Directed bench for uart_link_p: an 8N1 instance (a) and a 7E2 instance (b), both at DIV=1
// so one bit lasts 16 clocks.
module tb_uart_link_p;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance a: 8N1
  logic       wr_a = 0, rd_a = 0, loop_a = 1, clr_a = 0, sel_a = 0, rxd_a = 1;
  logic [7:0] w_a = 0, r_a;
  logic       full_a, empty_a, tx_a, rx_a, ep_a, ef_a, eo_a;
  assign rx_a = sel_a ? tx_a : rxd_a;

  uart_link_p #(.CLK_FREQ(1600000), .BAUD(100000), .DBITS(8), .PARITY(0), .SBITS(1),
                .FIFO_AW(2)) u_a (
    .clk(clk), .rst(rst), .wr_uart(wr_a), .w_data(w_a), .tx_full(full_a), .rd_uart(rd_a),
    .r_data(r_a), .rx_empty(empty_a), .rx(rx_a), .tx(tx_a), .loopback(loop_a),
    .err_clr(clr_a), .err_parity(ep_a), .err_frame(ef_a), .err_overrun(eo_a)
  );

  // Instance b: 7 data bits, even parity, 2 stop bits
  logic       wr_b = 0, rd_b = 0, clr_b = 0, sel_b = 0, rxd_b = 1;
  logic [6:0] w_b = 0, r_b;
  logic       full_b, empty_b, tx_b, rx_b, ep_b, ef_b, eo_b;
  assign rx_b = sel_b ? tx_b : rxd_b;

  uart_link_p #(.CLK_FREQ(1600000), .BAUD(100000), .DBITS(7), .PARITY(2), .SBITS(2),
                .FIFO_AW(2)) u_b (
    .clk(clk), .rst(rst), .wr_uart(wr_b), .w_data(w_b), .tx_full(full_b), .rd_uart(rd_b),
    .r_data(r_b), .rx_empty(empty_b), .rx(rx_b), .tx(tx_b), .loopback(1'b0),
    .err_clr(clr_b), .err_parity(ep_b), .err_frame(ef_b), .err_overrun(eo_b)
  );

  task automatic read_a();
    @(negedge clk); rd_a = 1;
    @(negedge clk); rd_a = 0;
  endtask

  task automatic read_b();
    @(negedge clk); rd_b = 1;
    @(negedge clk); rd_b = 0;
  endtask

  // Drive one 7E frame onto b's rx pin; a low stop bit is held for 12 clocks only.
  task automatic b_frame(input logic [6:0] d, input logic p, input logic stop_low);
    rxd_b = 0; repeat (16) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rxd_b = d[i]; repeat (16) @(negedge clk);
    end
    rxd_b = p; repeat (16) @(negedge clk);
    if (stop_low) begin
      rxd_b = 0; repeat (12) @(negedge clk);
    end
    rxd_b = 1; repeat (40) @(negedge clk);
  endtask

  int lows;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_tx_full", full_a, 0);
    check("rst_rx_empty", empty_a, 1);
    check("rst_r_data", r_a, 0);
    check("rst_errs", {ep_a, ef_a, eo_a}, 0);
    rst = 1;

    // Loopback single byte
    @(negedge clk); wr_a = 1; w_a = 8'hA5;
    @(negedge clk); wr_a = 0;
    repeat (20) @(negedge clk);
    check("lb_tx_held", tx_a, 1);
    repeat (148) @(negedge clk);
    check("lb_rx_empty", empty_a, 0);
    check("lb_r_data", r_a, 8'hA5);
    check("lb_errs", {ep_a, ef_a, eo_a}, 0);
    read_a();
    check("lb_drained", empty_a, 1);

    // Back-to-back frames on the pin, rx wired to tx; 6th write hits a full FIFO
    loop_a = 0; sel_a = 1;
    @(negedge clk); wr_a = 1; w_a = 8'h11;
    @(negedge clk); w_a = 8'h22; check("b2b_tx_idle0", tx_a, 1);
    @(negedge clk); w_a = 8'h33; check("b2b_tx_idle1", tx_a, 1);
    @(negedge clk); w_a = 8'h44; check("b2b_tx_latency", tx_a, 0);
    @(negedge clk); w_a = 8'h55;
    @(negedge clk); w_a = 8'h77;
    @(negedge clk); wr_a = 0;
    check("b2b_tx_full", full_a, 1);
    repeat (156) @(negedge clk);
    check("b2b_stop1", tx_a, 1);
    @(negedge clk); check("b2b_start2", tx_a, 0);
    for (int k = 3; k <= 5; k++) begin
      repeat (159) @(negedge clk);
      check($sformatf("b2b_stop%0d", k - 1), tx_a, 1);
      @(negedge clk); check($sformatf("b2b_start%0d", k), tx_a, 0);
    end
    repeat (159) @(negedge clk);
    check("b2b_stop5", tx_a, 1);
    @(negedge clk); check("b2b_no_6th", tx_a, 1);
    check("b2b_not_full", full_a, 0);
    repeat (20) @(negedge clk);
    check("ovr_flag", eo_a, 1);
    check("ovr_other_errs", {ep_a, ef_a}, 0);
    check("ovr_rx_empty", empty_a, 0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr_read%0d", k), r_a, 8'h11 * k);
      read_a();
    end
    check("ovr_drained", empty_a, 1);
    @(negedge clk); clr_a = 1;
    @(negedge clk); clr_a = 0;
    check("ovr_cleared", eo_a, 0);

    // Short low glitch on idle line
    sel_a = 0;
    @(negedge clk); rxd_a = 0;
    repeat (4) @(negedge clk); rxd_a = 1;
    repeat (60) @(negedge clk);
    check("glitch_empty", empty_a, 1);
    check("glitch_errs", {ep_a, ef_a, eo_a}, 0);

    // 7E2 receive errors and a good frame
    @(negedge clk);
    b_frame(7'h35, 1'b1, 1'b0);
    check("par_flag", ep_b, 1);
    check("par_empty", empty_b, 1);
    check("par_no_frame", ef_b, 0);
    b_frame(7'h35, 1'b0, 1'b1);
    check("frm_flag", ef_b, 1);
    check("frm_empty", empty_b, 1);
    b_frame(7'h2A, 1'b1, 1'b0);
    check("good_empty", empty_b, 0);
    check("good_data", r_b, 7'h2A);
    check("good_no_ovr", eo_b, 0);
    read_b();
    @(negedge clk); clr_b = 1;
    @(negedge clk); clr_b = 0;
    check("b_cleared", {ep_b, ef_b}, 0);

    // Two stop bits: frame period 11 bits = 176 clocks
    sel_b = 1;
    @(negedge clk); wr_b = 1; w_b = 7'h2A;
    @(negedge clk); w_b = 7'h55; check("sb2_idle0", tx_b, 1);
    @(negedge clk); wr_b = 0; check("sb2_idle1", tx_b, 1);
    @(negedge clk); check("sb2_start1", tx_b, 0);
    repeat (175) @(negedge clk); check("sb2_stop1", tx_b, 1);
    @(negedge clk); check("sb2_start2", tx_b, 0);
    repeat (175) @(negedge clk); check("sb2_stop2", tx_b, 1);
    @(negedge clk); check("sb2_idle_after", tx_b, 1);
    repeat (20) @(negedge clk);
    check("sb2_rx_empty", empty_b, 0);
    check("sb2_data0", r_b, 7'h2A);
    read_b();
    check("sb2_data1", r_b, 7'h55);
    read_b();
    check("sb2_drained", empty_b, 1);
    check("sb2_errs", {ep_b, ef_b, eo_b}, 0);

    // Reset in the middle of a frame of zeros
    sel_b = 0;
    @(negedge clk); wr_a = 1; w_a = 8'h00;
    repeat (5) @(negedge clk);
    wr_a = 0;
    repeat (40) @(negedge clk);
    check("mid_tx_full", full_a, 1);
    check("mid_tx_low", tx_a, 0);
    rst = 0;
    @(negedge clk);
    check("mrst_tx", tx_a, 1);
    check("mrst_tx_full", full_a, 0);
    check("mrst_rx_empty", empty_a, 1);
    check("mrst_r_data", r_a, 0);
    rst = 1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a == 1'b0) lows++;
    end
    check("mrst_tx_stays_idle", lows, 0);
    check("mrst_still_empty", empty_a, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
